ddr_cmd_sequencer: RTL
======================

Name: ddr_cmd_sequencer

Overview:
- Controller-side command issuer that sits directly upstream of the DIMM model.
- Accepts one read/write request at a time and tracks open rows per bank (open-page policy).
- Emits the PRE / ACT / RD / WR sequence on the DDR4 command/address pins, honouring tRP, tRCD, tRAS and tCCD.
- Pulses no_act_rdy on row hits, so the DIMM-side row tracking learns the row without an ACT.

Parameters:
- T_RCD, 4, cycles from ACT to RD/WR on the same bank (min 1).
- T_RP, 4, cycles from PRE to ACT on the same bank (min 1).
- T_RAS, 10, cycles from ACT to PRE on the same bank (min 1).
- T_CCD, 4, minimum cycles between consecutive RD/WR commands (min 1).
- ROW_W, 15, row address width (fixed 15: A14..A0).

Ports:
- CK_t  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_rw  in  1  1 = read, 0 = write.
- req_bl8  in  1  1 = BL8, 0 = BC4.
- req_bg  in  2  bank group.
- req_ba  in  2  bank.
- req_row  in  15  row address.
- req_col  in  10  column address.
- cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14  out  1 each  command pins.
- bg_addr, ba_addr  out  2 each  bank group / bank.
- A13, A12_BC_n, A11, A10_AP  out  1 each  address pins.
- A9_A0  out  10  address pins.
- no_act_rdy  out  1  row-hit strobe, coincident with the CAS.
- cas_issued  out  1  one-cycle strobe on the RD/WR command cycle.

Behaviour:
- Reset (sync, high): NOP on pins (cs_n=1, act_n=1, RAS/CAS/WE=1), address pins 0; req_ready=0, no_act_rdy=0, cas_issued=0; all 16 banks closed; all timers saturated (constraints already met). A reset mid-sequence abandons the request; NOP from the next edge.
- Handshake: req_ready=1 only in IDLE. Transfer occurs when req_valid & req_ready at an edge; request fields are latched. req_ready drops the following cycle and returns to 1 the cycle after the CAS.
- Per-bank state, indexed {bg,ba}: open flag, 15-bit open row, saturating ACT-age counter (for tRAS), saturating PRE-age counter (for tRP). One global saturating CAS-age counter (for tCCD).
- FSM: IDLE -> {PRE | ACT | CAS}, chosen by the latched request:
  - Bank open, row equal: CAS.
  - Bank open, row differs: PRE.
  - Bank closed: ACT.
- PRE: waits until ACT-age >= T_RAS, then drives one PRE cycle. Bank closes and PRE-age resets. Next state WAIT_RP.
- WAIT_RP: waits until PRE-age >= T_RP, then ACT.
- ACT: drives one ACT cycle; bank opens with the new row; ACT-age resets. Next state WAIT_RCD.
- WAIT_RCD: waits until ACT-age >= T_RCD, then CAS.
- CAS: waits until CAS-age >= T_CCD, then drives one RD or WR cycle and pulses cas_issued. no_act_rdy=1 in the same cycle only when entered directly from IDLE (row hit). Next state IDLE.
- Latency, request accepted at edge N, timers met:
  - Hit: CAS on pins for cycle N+1.
  - Closed bank: ACT at N+1, CAS at N+1+T_RCD.
  - Conflict: PRE at N+1, ACT at N+1+T_RP, CAS at N+1+T_RP+T_RCD.
- Pin encodings, {cs_n,act_n,RAS,CAS,WE}:
  - ACT = 0,0,1,1,row[14]; A13..A0 = row[13:0].
  - PRE = 0,1,0,1,0; A10_AP=0.
  - WR = 0,1,1,0,0; A9_A0=col; A12_BC_n=req_bl8; A10_AP=0.
  - RD = 0,1,1,0,1; A9_A0=col; A12_BC_n=req_bl8; A10_AP=0.
  - NOP: cs_n=1, all others 1.
- bg_addr/ba_addr hold the request's bank on every non-NOP cycle.
- All outputs are registered.
- Counters saturate at their maximum, never wrap. Counter width is clog2(max(T_*)+1).
- Only one command per cycle. Timers of other banks continue counting in every state.

Optional Feature:
- Macro: AUTO_PRECHARGE_EN.
- When defined:
  - Every RD/WR drives A10_AP=1.
  - The bank is marked closed at the CAS cycle, with PRE-age reset at CAS+T_RAS-relative completion treated as CAS cycle.
  - The next ACT to that bank waits PRE-age >= T_RP.
  - The PRE state is never entered and row hits never occur (no_act_rdy stays 0).
- When undefined: open-page behaviour as above.

Test Plan:
- Reset held 3 cycles, then released -> cs_n=1, req_ready=0 during reset; req_ready=1 one cycle after release.
- Write bg=1 ba=2 row=0x0123 col=0x040 BL8 accepted at edge N -> ACT at N+1 with A9_A0=0x123, A12_BC_n=0; WR at N+5 with A9_A0=0x040, A12_BC_n=1; cas_issued=1.
- Read of the same bank/row immediately after -> RD with no ACT; no_act_rdy=1 in the same cycle; RD spacing from the previous WR >= 4 cycles.
- Read bg=1 ba=2 row=0x0456 issued 2 cycles after the ACT -> PRE held off until ACT-age reaches 10; then PRE, ACT 4 cycles later with row 0x456, RD 4 cycles after that.
- Reset asserted during WAIT_RCD -> next cycle NOP, all banks closed; a subsequent request to the same row issues ACT, not a hit.
- With AUTO_PRECHARGE_EN, two writes to the same row -> each WR has A10_AP=1; second write issues ACT >= 4 cycles after the first WR; no_act_rdy never 1.

Source files
------------

// File: rtl/ddr_cmd_sequencer.sv
// DDR4 command sequencer: open-page PRE/ACT/RD/WR issue with tRP/tRCD/tRAS/tCCD timers.
// Define AUTO_PRECHARGE_EN to issue every RD/WR with auto-precharge (closed-page).
//
// state    | meaning
// ---------+------------------------------------------------
// IDLE     | ready for a request, pins NOP
// PRE      | row conflict, waiting tRAS then precharge
// WAIT_RP  | precharge done, waiting tRP
// ACT      | activate the requested row (once tRP met)
// WAIT_RCD | row open, waiting tRCD
// CAS      | waiting tCCD then RD/WR
module ddr_cmd_sequencer #(
  parameter int T_RCD = 4,
  parameter int T_RP  = 4,
  parameter int T_RAS = 10,
  parameter int T_CCD = 4,
  parameter int ROW_W = 15
) (
  input  logic             CK_t,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_rw,
  input  logic             req_bl8,
  input  logic [1:0]       req_bg,
  input  logic [1:0]       req_ba,
  input  logic [ROW_W-1:0] req_row,
  input  logic [9:0]       req_col,
  output logic             cs_n,
  output logic             act_n,
  output logic             RAS_n_A16,
  output logic             CAS_n_A15,
  output logic             WE_n_A14,
  output logic [1:0]       bg_addr,
  output logic [1:0]       ba_addr,
  output logic             A13,
  output logic             A12_BC_n,
  output logic             A11,
  output logic             A10_AP,
  output logic [9:0]       A9_A0,
  output logic             no_act_rdy,
  output logic             cas_issued
);

`ifdef AUTO_PRECHARGE_EN
  localparam logic AP = 1'b1;
`else
  localparam logic AP = 1'b0;
`endif

  localparam int T_M1  = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int T_M2  = (T_RAS > T_CCD) ? T_RAS : T_CCD;
  localparam int T_MAX = (T_M1 > T_M2) ? T_M1 : T_M2;
  localparam int CW    = $clog2(T_MAX + 1);
  typedef logic [CW-1:0] age_t;

  // Ages read 1 on the cycle after their command, so "age >= T" means the
  // command may go out on the next edge.  WAIT states look one cycle ahead
  // to absorb the extra cycle spent in the issuing state.
  localparam age_t SAT    = '1;
  localparam age_t ONE    = age_t'(1);
  localparam age_t RAS_T  = age_t'(T_RAS);
  localparam age_t RP_T   = age_t'(T_RP);
  localparam age_t RP_LA  = age_t'(T_RP - 1);
  localparam age_t RCD_LA = age_t'(T_RCD - 1);
  localparam age_t CCD_T  = age_t'(T_CCD);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_CAS} state_t;

  state_t           state, state_nxt;
  logic             bank_open [16];
  logic [ROW_W-1:0] open_row [16];
  age_t             act_age [16];
  age_t             pre_age [16];
  age_t             cas_age;
  logic [3:0]       lat_bank, req_bank;
  logic [ROW_W-1:0] lat_row;
  logic [9:0]       lat_col;
  logic             lat_rw, lat_bl8, hit_q;
  logic             take, take_hit, do_pre, do_act, do_cas;
  logic [4:0]       cmd_nxt;
  logic [3:0]       a13_10_nxt;
  logic [9:0]       a9_0_nxt;
  logic [3:0]       bank_nxt;

  assign req_bank = {req_bg, req_ba};

  function automatic age_t sat_inc(input age_t v);
    return (v == SAT) ? v : v + ONE;
  endfunction

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    take_hit  = 1'b0;
    do_pre    = 1'b0;
    do_act    = 1'b0;
    do_cas    = 1'b0;
    case (state)
      S_IDLE: if (req_valid && req_ready) begin
        take = 1'b1;
        if (!AP && bank_open[req_bank] && open_row[req_bank] == req_row) begin
          take_hit  = 1'b1;
          state_nxt = S_CAS;
        end else if (!AP && bank_open[req_bank]) begin
          state_nxt = S_PRE;
        end else begin
          state_nxt = S_ACT;
        end
      end
      S_PRE: if (act_age[lat_bank] >= RAS_T) begin
        do_pre    = 1'b1;
        state_nxt = S_WAIT_RP;
      end
      S_WAIT_RP: if (pre_age[lat_bank] >= RP_LA) state_nxt = S_ACT;
      S_ACT: if (pre_age[lat_bank] >= RP_T) begin
        do_act    = 1'b1;
        state_nxt = S_WAIT_RCD;
      end
      S_WAIT_RCD: if (act_age[lat_bank] >= RCD_LA) state_nxt = S_CAS;
      S_CAS: if (cas_age >= CCD_T) begin
        do_cas    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_nxt    = 5'b11111;
    bank_nxt   = 4'd0;
    a13_10_nxt = 4'd0;
    a9_0_nxt   = 10'd0;
    if (do_act) begin
      cmd_nxt    = {4'b0011, lat_row[14]};
      bank_nxt   = lat_bank;
      a13_10_nxt = lat_row[13:10];
      a9_0_nxt   = lat_row[9:0];
    end else if (do_pre) begin
      cmd_nxt  = 5'b01010;
      bank_nxt = lat_bank;
    end else if (do_cas) begin
      cmd_nxt    = {4'b0110, lat_rw};
      bank_nxt   = lat_bank;
      a13_10_nxt = {1'b0, lat_bl8, 1'b0, AP};
      a9_0_nxt   = lat_col;
    end
  end

  always_ff @(posedge CK_t) begin
    if (reset) begin
      state      <= S_IDLE;
      req_ready  <= 1'b0;
      {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14} <= 5'b11111;
      {bg_addr, ba_addr}              <= 4'd0;
      {A13, A12_BC_n, A11, A10_AP}    <= 4'd0;
      A9_A0      <= 10'd0;
      no_act_rdy <= 1'b0;
      cas_issued <= 1'b0;
      cas_age    <= SAT;
      lat_bank   <= 4'd0;
      lat_row    <= '0;
      lat_col    <= 10'd0;
      lat_rw     <= 1'b0;
      lat_bl8    <= 1'b0;
      hit_q      <= 1'b0;
      for (int b = 0; b < 16; b++) begin
        bank_open[b] <= 1'b0;
        open_row[b]  <= '0;
        act_age[b]   <= SAT;
        pre_age[b]   <= SAT;
      end
    end else begin
      state      <= state_nxt;
      req_ready  <= (state_nxt == S_IDLE);
      {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14} <= cmd_nxt;
      {bg_addr, ba_addr}              <= bank_nxt;
      {A13, A12_BC_n, A11, A10_AP}    <= a13_10_nxt;
      A9_A0      <= a9_0_nxt;
      no_act_rdy <= do_cas & hit_q;
      cas_issued <= do_cas;
      cas_age    <= do_cas ? ONE : sat_inc(cas_age);
      if (take) begin
        lat_bank <= req_bank;
        lat_row  <= req_row;
        lat_col  <= req_col;
        lat_rw   <= req_rw;
        lat_bl8  <= req_bl8;
        hit_q    <= take_hit;
      end
      for (int b = 0; b < 16; b++) begin
        act_age[b] <= (do_act && lat_bank == 4'(b)) ? ONE : sat_inc(act_age[b]);
        pre_age[b] <= ((do_pre || (AP && do_cas)) && lat_bank == 4'(b)) ? ONE
                                                                     : sat_inc(pre_age[b]);
      end
      if (do_act) begin
        bank_open[lat_bank] <= 1'b1;
        open_row[lat_bank]  <= lat_row;
      end else if (do_pre || (AP && do_cas)) begin
        bank_open[lat_bank] <= 1'b0;
      end
    end
  end

endmodule
